// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA raster constant sets and axis-total helper
package vga_timing_pkg;

  typedef struct packed {
    int visible;
    int front;
    int sync;
    int back;
  } axis_timing_t;

  // 1024x768@60 (65 MHz pixel clock)
  localparam axis_timing_t VGA_1024X768_H = '{visible: 1024, front: 24, sync: 136, back: 160};
  localparam axis_timing_t VGA_1024X768_V = '{visible: 768, front: 3, sync: 6, back: 29};
  localparam int VGA_1024X768_CNT_WIDTH = 11;

  // 640x480@60 (25.175 MHz pixel clock)
  localparam axis_timing_t VGA_640X480_H = '{visible: 640, front: 16, sync: 96, back: 48};
  localparam axis_timing_t VGA_640X480_V = '{visible: 480, front: 10, sync: 2, back: 33};
  localparam int VGA_640X480_CNT_WIDTH = 10;

  function automatic int axis_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster position/sync bundle; frame_count with VGA_TIMING_FRAME_COUNT_EN
interface vga_timing_gen_if #(
  parameter int CNT_WIDTH = 11
);
  logic                 pixel_enable;
  logic [CNT_WIDTH-1:0] h_count;
  logic [CNT_WIDTH-1:0] v_count;
  logic                 display_enable;
  logic                 hsync;
  logic                 vsync;
  logic                 line_start;
  logic                 frame_start;
`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [7:0]           frame_count;

  modport master (
    input  pixel_enable,
    output h_count, v_count, display_enable, hsync, vsync,
    output line_start, frame_start, frame_count
  );
  modport slave (
    output pixel_enable,
    input  h_count, v_count, display_enable, hsync, vsync,
    input  line_start, frame_start, frame_count
  );
`else
  modport master (
    input  pixel_enable,
    output h_count, v_count, display_enable, hsync, vsync,
    output line_start, frame_start
  );
  modport slave (
    output pixel_enable,
    input  h_count, v_count, display_enable, hsync, vsync,
    input  line_start, frame_start
  );
`endif
endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: count, wrap, active and sync decode
module vga_axis_counter #(
  parameter int VISIBLE = 1024,
  parameter int FRONT   = 24,
  parameter int SYNC    = 136,
  parameter int BACK    = 160,
  parameter int WIDTH   = 11,
  parameter bit POL     = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             active,
  output logic             sync,
  output logic             start,
  output logic             at_end
);
  localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(TOTAL - 1);
  localparam logic [WIDTH-1:0] VIS_END = WIDTH'(VISIBLE);
  localparam logic [WIDTH-1:0] SYNC_LO = WIDTH'(VISIBLE + FRONT);
  localparam logic [WIDTH-1:0] SYNC_HI = WIDTH'(VISIBLE + FRONT + SYNC);

  logic [WIDTH-1:0] next_count;
  logic             next_in_sync;

  assign at_end       = (count == LAST);
  assign next_count   = at_end ? '0 : count + WIDTH'(1);
  assign next_in_sync = (next_count >= SYNC_LO) && (next_count < SYNC_HI);

  // Flags decode the position being loaded so they line up with count.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= LAST;
      active <= 1'b0;
      sync   <= ~POL;
      start  <= 1'b0;
    end else if (enable) begin
      count  <= next_count;
      active <= (next_count < VIS_END);
      sync   <= next_in_sync ? POL : ~POL;
      start  <= (next_count == '0);
    end else begin
      start  <= 1'b0;
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator; VGA_TIMING_FRAME_COUNT_EN adds frame_count
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = VGA_1024X768_H.visible,
  parameter int H_FRONT   = VGA_1024X768_H.front,
  parameter int H_SYNC    = VGA_1024X768_H.sync,
  parameter int H_BACK    = VGA_1024X768_H.back,
  parameter int V_VISIBLE = VGA_1024X768_V.visible,
  parameter int V_FRONT   = VGA_1024X768_V.front,
  parameter int V_SYNC    = VGA_1024X768_V.sync,
  parameter int V_BACK    = VGA_1024X768_V.back,
  parameter int CNT_WIDTH = VGA_1024X768_CNT_WIDTH,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0
) (
  input  logic            slow_clock,
  input  logic            reset,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  if (H_TOTAL > (1 << CNT_WIDTH) || V_TOTAL > (1 << CNT_WIDTH)) begin : g_bad_width
    $error("vga_timing_gen: axis total exceeds counter range");
  end
  if (H_VISIBLE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_VISIBLE == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_param
    $error("vga_timing_gen: zero-length timing region");
  end

  logic h_active, h_sync, h_start, h_at_end;
  logic v_active, v_sync, v_start, v_at_end;
  logic v_enable;

  // The vertical axis steps only on the enabled edge that wraps the line.
  assign v_enable = vga.pixel_enable && h_at_end;

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .WIDTH(CNT_WIDTH), .POL(HSYNC_POL != 0)
  ) u_h_axis (
    .clk(slow_clock), .reset(reset), .enable(vga.pixel_enable),
    .count(vga.h_count), .active(h_active), .sync(h_sync),
    .start(h_start), .at_end(h_at_end)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .WIDTH(CNT_WIDTH), .POL(VSYNC_POL != 0)
  ) u_v_axis (
    .clk(slow_clock), .reset(reset), .enable(v_enable),
    .count(vga.v_count), .active(v_active), .sync(v_sync),
    .start(v_start), .at_end(v_at_end)
  );

  assign vga.display_enable = h_active && v_active;
  assign vga.hsync          = h_sync;
  assign vga.vsync          = v_sync;
  assign vga.line_start     = h_start;
  assign vga.frame_start    = h_start && v_start;

`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [7:0] frame_count_q;

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      frame_count_q <= 8'd0;
    end else if (v_enable && v_at_end) begin
      frame_count_q <= frame_count_q + 8'd1;
    end
  end

  assign vga.frame_count = frame_count_q;
`endif
endmodule
